// File: rtl/cnn_layer_accel_weight_config_streamer_if.sv
// Upstream weight-word stream: data/valid from the source, ready from the streamer.
interface cnn_layer_accel_weight_config_streamer_if #(
  parameter int C_WEIGHT_WIDTH = 16
);
  logic [C_WEIGHT_WIDTH-1:0] wht_in_data;
  logic                      wht_in_valid;
  logic                      wht_in_ready;

  // Source side (upstream word producer)
  modport master (
    output wht_in_data,
    output wht_in_valid,
    input  wht_in_ready
  );

  // Sink side (the streamer)
  modport slave (
    input  wht_in_data,
    input  wht_in_valid,
    output wht_in_ready
  );
endinterface

// File: rtl/cnn_layer_accel_weight_config_streamer.sv
// Weight configuration streamer: accepts a job, then forwards C_KERNEL_SIZE
// weights per kernel into the weight table, inserting one idle write-mode
// cycle between kernels so the table wraps its count and advances its group.
module cnn_layer_accel_weight_config_streamer #(
  parameter int C_WEIGHT_WIDTH = 16,
  parameter int C_KERNEL_SIZE  = 9,
  parameter int C_KGRP_WIDTH   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [C_KGRP_WIDTH-1:0]   num_kernels_m1_i,
  cnn_layer_accel_weight_config_streamer_if.slave wht_in,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      job_accept_o,
  output logic                      kernel_config_valid_o,
  output logic [15:0]               kernel_full_count_o,
  output logic                      config_mode_o,
  output logic                      wht_config_wren_o,
  output logic [C_WEIGHT_WIDTH-1:0] wht_config_data_o
);

  localparam int BEAT_W = (C_KERNEL_SIZE > 1) ? $clog2(C_KERNEL_SIZE) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(C_KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_CFG    = 3'd2,
    S_STREAM = 3'd3,
    S_GAP    = 3'd4,
    S_TAIL   = 3'd5,
    S_FLUSH  = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [C_KGRP_WIDTH-1:0]   kern_q, kern_d;
  logic [C_KGRP_WIDTH-1:0]   nk_q, nk_d;
  logic                      done_q;
  logic                      wren_q;
  logic [C_WEIGHT_WIDTH-1:0] data_q;

  logic in_ready_s;
  logic accept_s;

  assign in_ready_s = (state_q == S_STREAM);
  assign accept_s   = in_ready_s && wht_in.wht_in_valid;

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    kern_d  = kern_q;
    nk_d    = nk_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ACCEPT;
          nk_d    = num_kernels_m1_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        beat_d  = '0;
        kern_d  = '0;
        state_d = S_CFG;
      end
      S_CFG: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept_s) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = S_GAP;
          end else begin
            beat_d  = beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_GAP: begin
        // Compare before incrementing: kern_q is the index of the kernel just finished
        kern_d = kern_q + {{(C_KGRP_WIDTH-1){1'b0}}, 1'b1};
        if (kern_q == nk_q) begin
          state_d = S_TAIL;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_TAIL: begin
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered write/done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      kern_q  <= '0;
      nk_q    <= '0;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      kern_q  <= kern_d;
      nk_q    <= nk_d;
      done_q  <= (state_q == S_FLUSH);
      wren_q  <= accept_s;
      data_q  <= accept_s ? wht_in.wht_in_data : data_q;
    end
  end

  // Control outputs decoded purely from the registered state
  always_comb begin
    job_accept_o          = 1'b0;
    kernel_config_valid_o = 1'b0;
    config_mode_o         = 1'b0;
    case (state_q)
      S_ACCEPT: job_accept_o = 1'b1;
      S_CFG: begin
        kernel_config_valid_o = 1'b1;
        config_mode_o         = 1'b1;
      end
      S_STREAM: config_mode_o = 1'b1;
      S_GAP:    config_mode_o = 1'b1;
      S_TAIL:   config_mode_o = 1'b1;
      S_FLUSH:  job_accept_o  = 1'b1;
      default: begin
        job_accept_o          = 1'b0;
        kernel_config_valid_o = 1'b0;
        config_mode_o         = 1'b0;
      end
    endcase
  end

  assign wht_in.wht_in_ready = in_ready_s;
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = done_q;
  assign kernel_full_count_o = 16'(nk_q);
  assign wht_config_wren_o   = wren_q;
  assign wht_config_data_o   = data_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_config_streamer.sv
// Bench for the weight configuration streamer: table of jobs plus a reset-abort
// sequence; accepted words go to a scoreboard and are matched against writes.
module tb_cnn_layer_accel_weight_config_streamer;
  localparam int W  = 16;
  localparam int KS = 9;
  localparam int KG = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KG-1:0] nk;
  logic          busy, done, job_accept, kcv, config_mode, wren;
  logic [15:0]   kfc;
  logic [W-1:0]  wdata;

  cnn_layer_accel_weight_config_streamer_if #(.C_WEIGHT_WIDTH(W)) wif ();

  cnn_layer_accel_weight_config_streamer #(
    .C_WEIGHT_WIDTH(W), .C_KERNEL_SIZE(KS), .C_KGRP_WIDTH(KG)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .num_kernels_m1_i(nk),
    .wht_in(wif),
    .busy_o(busy), .done_o(done), .job_accept_o(job_accept),
    .kernel_config_valid_o(kcv), .kernel_full_count_o(kfc),
    .config_mode_o(config_mode), .wht_config_wren_o(wren),
    .wht_config_data_o(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nk; int stall_after; int stall_len; int repulse; int base;
    int done_off; int writes;
  } vec_t;
  typedef struct { logic [W-1:0] data; int due; } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  int checks = 0, errors = 0, cyc = 0, wren_total = 0;
  int wi, stall_rem, cur_base, cur_stall_after;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_job_accept"}, job_accept, 0);
    check({tag, "_kcv"}, kcv, 0);
    check({tag, "_kfc"}, kfc, 0);
    check({tag, "_config_mode"}, config_mode, 0);
    check({tag, "_wren"}, wren, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_ready"}, wif.wht_in_ready, 0);
  endtask

  // Drive the upstream word for the current cycle; count it if it will be accepted.
  task automatic set_word();
    if (wif.wht_in_ready && wi == cur_stall_after && stall_rem > 0) begin
      wif.wht_in_valid = 1'b0;
      stall_rem--;
      check("stall_config_mode", config_mode, 1);
    end else begin
      wif.wht_in_valid = 1'b1;
      wif.wht_in_data  = W'(cur_base + wi + 1);
      if (wif.wht_in_ready) wi++;
    end
  endtask

  task automatic run_job(input vec_t v);
    int t0, c, w0, g;
    bit done_seen;
    cur_base = v.base; stall_rem = v.stall_len; cur_stall_after = v.stall_after; wi = 0;
    w0 = wren_total;
    t0 = cyc;
    start = 1'b1;
    nk = KG'(v.nk);
    set_word();
    done_seen = 1'b0;
    for (int k = 0; k < v.done_off + 20 && !done_seen; k++) begin
      step();
      c = cyc - t0;
      start = (c == v.repulse);
      if (c == v.repulse) nk = KG'(v.nk ^ 5);
      if (c == 1) begin
        check("accept_pulse", job_accept, 1);
        check("accept_busy", busy, 1);
        check("accept_kcv", kcv, 0);
      end
      if (c == 2) begin
        check("cfg_kcv", kcv, 1);
        check("cfg_mode", config_mode, 1);
        check("cfg_job_accept", job_accept, 0);
      end
      if (c >= 2) check("kfc_hold", kfc, v.nk);
      g = c - 13 - v.stall_len;
      if (g >= 0 && g % 10 == 0 && g / 10 <= v.nk) begin
        check("gap_wren", wren, 0);
        check("gap_mode", config_mode, 1);
      end
      if (c == v.done_off - 1) begin
        check("flush_job_accept", job_accept, 1);
        check("flush_mode", config_mode, 0);
      end
      if (done) begin
        check("done_cycle", c, v.done_off);
        done_seen = 1'b1;
      end
      set_word();
    end
    if (!done_seen) check("done_timeout", 0, 1);
    start = 1'b0;
    wif.wht_in_valid = 1'b0;
    check("write_count", wren_total - w0, v.writes);
    for (int q = 0; q < 4; q++) begin
      step();
      check("quiet_done", done, 0);
      check("quiet_busy", busy, 0);
    end
    check("scoreboard_empty", sbq.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Scoreboard monitor: every accepted word must be written exactly one cycle later.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      sbq.delete();
    end else begin
      check("wren_without_mode", wren && !config_mode, 0);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        check("wren_on_time", wren, 1);
        check("wr_data", wdata, sbq[0].data);
        void'(sbq.pop_front());
      end else begin
        check("wren_unexpected", wren, 0);
      end
      if (wren) wren_total++;
      if (wif.wht_in_valid && wif.wht_in_ready)
        sbq.push_back('{data: wif.wht_in_data, due: cyc + 1});
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0,  0, 0, -1, 0,   15,  9};
    vecs[1] = '{1,  0, 0, -1, 0,   25,  18};
    vecs[2] = '{0,  4, 3, -1, 100, 18,  9};
    vecs[3] = '{0,  0, 0, 6,  200, 15,  9};
    vecs[4] = '{63, 0, 0, -1, 500, 645, 576};
    vecs[5] = '{5,  2, 1, 4,  300, 66,  54};

    rst = 1'b1; start = 1'b0; nk = '0;
    wif.wht_in_valid = 1'b0; wif.wht_in_data = '0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_job(vecs[i]);

    // Abort mid-STREAM after the 5th word, then a clean job right after release.
    cur_base = 900; stall_rem = 0; cur_stall_after = 0; wi = 0;
    start = 1'b1; nk = KG'(2);
    set_word();
    for (int k = 0; k < 40 && wi < 5; k++) begin
      step();
      start = 1'b0;
      set_word();
    end
    check("abort_reached_word5", wi, 5);
    step();
    check("abort_pre_wren", wren, 1);
    wif.wht_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_done", done, 0);
      check("abort_no_wren", wren, 0);
    end
    rst = 1'b0;
    run_job(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cnn_layer_accel_weight_config_streamer.md
CNN_LAYER_ACCEL_WEIGHT_CONFIG_STREAMER -- requirements
Module: cnn_layer_accel_weight_config_streamer

Interface
REQ-001 Parameter C_WEIGHT_WIDTH, default 16: width of one weight word.
REQ-002 Parameter C_KERNEL_SIZE, default 9: weights per kernel (3x3).
REQ-003 Parameter C_KGRP_WIDTH, default 6: width of kernel-group index.
REQ-004 The block has one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-008 num_kernels_m1  in  C_KGRP_WIDTH  kernel count minus one; sampled with start.
REQ-009 wht_in_data  in  C_WEIGHT_WIDTH  upstream weight word.
REQ-010 wht_in_valid  in  1  upstream word valid.
REQ-011 wht_in_ready  out  1  block accepts a word when valid and ready are both high.
REQ-012 busy  out  1  high from the cycle after accepted start until the cycle done is high.
REQ-013 done  out  1  one-cycle pulse at job end.
REQ-014 job_accept  out  1  weight-table counter/group clear pulse.
REQ-015 kernel_config_valid  out  1  one-cycle pulse qualifying kernel_full_count.
REQ-016 kernel_full_count  out  16  zero-extended latched num_kernels_m1.
REQ-017 config_mode  out  1  weight-table write mode.
REQ-018 wht_config_wren  out  1  weight-table write enable.
REQ-019 wht_config_data  out  C_WEIGHT_WIDTH  weight-table write data.

Function
REQ-020 FSM states SHALL be IDLE, ACCEPT, CFG, STREAM, GAP, TAIL, FLUSH.
REQ-021 IDLE->ACCEPT on start; start SHALL be ignored in every other state.
REQ-022 ACCEPT (1 cycle): job_accept=1; ->CFG.
REQ-023 CFG (1 cycle): kernel_config_valid=1, config_mode=1; ->STREAM.
REQ-024 STREAM: wht_in_ready=1, config_mode=1; the 9th accepted word of a kernel SHALL move to GAP.
REQ-025 GAP (1 cycle): wht_in_ready=0, config_mode=1; ->STREAM if kernels remain, else ->TAIL.
REQ-026 TAIL (1 cycle): config_mode=1, wht_config_wren=0; ->FLUSH.
REQ-027 FLUSH (1 cycle): config_mode=0, job_accept=1; ->IDLE, done=1 in the following cycle.
REQ-028 job_accept, kernel_config_valid, config_mode, wht_in_ready, busy SHALL be decoded from the registered state only; no combinational input-to-output path.
REQ-029 Each accepted word SHALL appear on wht_config_data with wht_config_wren=1 exactly one cycle later; wht_config_wren=0 otherwise.
REQ-030 Between consecutive kernels there SHALL be at least one cycle with wren=0 and config_mode=1 after the 9th write, so the table wraps its count and advances its group.
REQ-031 wht_config_wren SHALL never be high while config_mode is low.
REQ-032 Beat counter 0..C_KERNEL_SIZE-1 wraps to 0 on the 9th accept; kernel counter increments at GAP and compares to latched num_kernels_m1.
REQ-033 wht_in_valid low in STREAM SHALL stall without state change; config_mode stays high.
REQ-034 kernel_full_count SHALL hold its value from CFG until the next accepted start.
REQ-035 Per job: 1 + 1 + 10*(num_kernels_m1+1) + 1 + 1 cycles from ACCEPT to done with no stalls.

Reset
REQ-036 rst high SHALL force IDLE and drive every output and counter to 0 immediately, including mid-job; no done is issued for the aborted job.
REQ-037 After rst release the block SHALL accept start in the next cycle.

Verification
REQ-038 start at T, num_kernels_m1=0, valid always high, data 1..9 -> job_accept T+1, kernel_config_valid T+2 with kernel_full_count=0, wren T+4..T+12 with data 1..9, wren=0 with config_mode=1 at T+13, job_accept=1 with config_mode=0 at T+14, done T+15.
REQ-039 num_kernels_m1=1, data 1..18 -> wren=0 at T+13, second kernel writes data 10..18 at T+14..T+22, done T+25, exactly 18 wren pulses.
REQ-040 valid low for 3 cycles after word 4 -> ready stays high, config_mode stays high, wren gap of 3 cycles, done delayed by 3 cycles.
REQ-041 start re-pulsed at T+6 during a job -> ignored, kernel_full_count unchanged, single done.
REQ-042 rst asserted mid-STREAM after word 5 -> all outputs 0 at once, no done; new start after release completes normally.
REQ-043 num_kernels_m1=63 -> kernel_full_count=63, 576 writes, done at T+1+1+640+1+1+1.
